// File: rtl/booth_r4_mul.sv
// booth_r4_mul: radix-4 modified-Booth sequential multiplier, signed/unsigned per operation,
// valid/ready on operands and result.
module booth_r4_mul #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           signed_mode,
    input  logic [N-1:0]   multiplicand,
    input  logic [N-1:0]   multiplier,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] product,
    output logic           busy
);
    localparam int ITER = (N + 2) / 2;
    localparam int QW = 2 * ITER;
    localparam int CW = $clog2(ITER + 1);
    localparam int PW = 2 * N;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t state, next_state;
    logic [N+1:0] a, m, m2, addend, sum;
    logic [QW-1:0] q;
    logic q1;
    logic [CW-1:0] cnt;
    logic [2:0] sel;

    assign in_ready = state == IDLE;
    assign out_valid = state == DONE;
    assign busy = state != IDLE;

    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else state <= next_state;

    always_comb begin
        next_state = state;
        next_state = (state == IDLE && in_valid) ? CALC :
                     (state == CALC && cnt == '0) ? DONE :
                     (state == DONE && out_ready) ? IDLE : state;
    end

    // Booth recode of the low multiplier pair plus the previously shifted-out bit
    always_comb begin
        sel = {q[1:0], q1};
        m2 = m << 1;
        addend = (sel == 3'b001 || sel == 3'b010) ? m :
                 (sel == 3'b011) ? m2 :
                 (sel == 3'b100) ? -m2 :
                 (sel == 3'b101 || sel == 3'b110) ? -m : '0;
        sum = a + addend;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a <= '0;
            q <= '0;
            q1 <= 1'b0;
            m <= '0;
            cnt <= '0;
            product <= '0;
        end else if (state == IDLE && in_valid) begin
            m <= {{2{signed_mode & multiplicand[N-1]}}, multiplicand};
            q <= {{(QW-N){signed_mode & multiplier[N-1]}}, multiplier};
            a <= '0;
            q1 <= 1'b0;
            cnt <= CW'(ITER);
        end else if (state == CALC) begin
            if (cnt != '0) begin
                {a, q, q1} <= {{2{sum[N+1]}}, sum, q[QW-1:1]};
                cnt <= cnt - CW'(1);
            end else begin
                product <= PW'({a, q});
            end
        end
    end
endmodule

// File: tb/tb_booth_r4_mul.sv
// tb_booth_r4_mul: checks N=8 and N=7 builds against an arithmetic reference model.
module tb_booth_r4_mul;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic iv8 = 0, ir8, sm8 = 0, ov8, or8 = 0, busy8;
    logic [7:0] mc8 = '0, mq8 = '0;
    logic [15:0] p8;
    logic iv7 = 0, ir7, sm7 = 0, ov7, or7 = 0, busy7;
    logic [6:0] mc7 = '0, mq7 = '0;
    logic [13:0] p7;

    booth_r4_mul #(.N(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .signed_mode(sm8),
        .multiplicand(mc8), .multiplier(mq8), .out_valid(ov8), .out_ready(or8),
        .product(p8), .busy(busy8)
    );
    booth_r4_mul #(.N(7)) dut7 (
        .clk(clk), .rst(rst), .in_valid(iv7), .in_ready(ir7), .signed_mode(sm7),
        .multiplicand(mc7), .multiplier(mq7), .out_valid(ov7), .out_ready(or7),
        .product(p7), .busy(busy7)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Exact product of two n-bit operands, truncated to 2n bits
    function automatic logic [63:0] ref_mul(input int n, input bit s, input logic [63:0] a,
                                            input logic [63:0] b);
        logic [63:0] mask;
        mask = (64'd1 << n) - 64'd1;
        a &= mask;
        b &= mask;
        if (s && a[n-1]) a |= ~mask;
        if (s && b[n-1]) b |= ~mask;
        return (a * b) & ((64'd1 << (2 * n)) - 64'd1);
    endfunction

    task automatic op8(input bit s, input logic [7:0] a, input logic [7:0] b,
                       output logic [15:0] p, output int lat);
        int w;
        w = 0;
        while (!ir8 && w < 20) begin @(posedge clk); #1; w++; end
        iv8 = 1; sm8 = s; mc8 = a; mq8 = b;
        @(posedge clk); #1;
        iv8 = 0; sm8 = ~s; mc8 = 8'($urandom); mq8 = 8'($urandom);
        lat = 0;
        while (!ov8 && lat < 50) begin @(posedge clk); #1; lat++; end
        p = p8;
        or8 = 1;
        @(posedge clk); #1;
        or8 = 0;
    endtask

    task automatic op7(input bit s, input logic [6:0] a, input logic [6:0] b,
                       output logic [13:0] p, output int lat);
        int w;
        w = 0;
        while (!ir7 && w < 20) begin @(posedge clk); #1; w++; end
        iv7 = 1; sm7 = s; mc7 = a; mq7 = b;
        @(posedge clk); #1;
        iv7 = 0; sm7 = ~s; mc7 = 7'($urandom); mq7 = 7'($urandom);
        lat = 0;
        while (!ov7 && lat < 50) begin @(posedge clk); #1; lat++; end
        p = p7;
        or7 = 1;
        @(posedge clk); #1;
        or7 = 0;
    endtask

    typedef struct {
        bit s;
        logic [7:0] a;
        logic [7:0] b;
        logic [15:0] p;
    } vec_t;

    initial begin
        vec_t vt[9];
        logic [15:0] p;
        logic [13:0] q;
        logic [15:0] held;
        int lat;
        vt[0] = '{1, 8'h80, 8'h80, 16'h4000};
        vt[1] = '{0, 8'hFF, 8'hFF, 16'hFE01};
        vt[2] = '{1, 8'hFF, 8'hFF, 16'h0001};
        vt[3] = '{0, 8'h80, 8'h03, 16'h0180};
        vt[4] = '{1, 8'h80, 8'h03, 16'hFE80};
        vt[5] = '{1, 8'hFD, 8'h05, 16'hFFF1};
        vt[6] = '{0, 8'h07, 8'h06, 16'h002A};
        vt[7] = '{1, 8'h7F, 8'h80, 16'hC080};
        vt[8] = '{0, 8'h00, 8'hFF, 16'h0000};

        #1;
        chk("reset_in_ready", ir8, 1);
        chk("reset_out_valid", ov8, 0);
        chk("reset_busy", busy8, 0);
        chk("reset_product", p8, 0);
        @(negedge clk); rst = 1;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) begin
            op8(vt[i].s, vt[i].a, vt[i].b, p, lat);
            chk($sformatf("vec%0d_product", i), p, vt[i].p);
            chk($sformatf("vec%0d_latency", i), lat, 6);
        end

        // Backpressure: product held, operands presented in DONE are not taken
        iv8 = 1; sm8 = 0; mc8 = 8'h12; mq8 = 8'h34;
        @(posedge clk); #1;
        chk("bp_busy_after_accept", busy8, 1);
        mc8 = 8'h02; mq8 = 8'h03;
        lat = 0;
        while (!ov8 && lat < 50) begin @(posedge clk); #1; lat++; end
        chk("bp_latency", lat, 6);
        held = p8;
        chk("bp_product", held, 16'h03A8);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_hold_product", p8, held);
            chk("bp_hold_valid", ov8, 1);
            chk("bp_hold_in_ready", ir8, 0);
        end
        or8 = 1;
        @(posedge clk); #1;
        or8 = 0;
        chk("bp_release_valid", ov8, 0);
        chk("bp_release_in_ready", ir8, 1);
        chk("bp_release_product_kept", p8, 16'h03A8);
        @(posedge clk); #1;
        iv8 = 0;
        chk("bp_next_accept", busy8, 1);
        lat = 0;
        while (!ov8 && lat < 50) begin @(posedge clk); #1; lat++; end
        chk("bp_next_latency", lat, 6);
        chk("bp_next_product", p8, 16'h0006);
        or8 = 1;
        @(posedge clk); #1;
        or8 = 0;

        // Asynchronous reset during the calculation
        iv8 = 1; sm8 = 1; mc8 = 8'h55; mq8 = 8'h66;
        @(posedge clk); #1;
        iv8 = 0;
        @(posedge clk); @(posedge clk); #3;
        rst = 0;
        #1;
        chk("async_rst_in_ready", ir8, 1);
        chk("async_rst_out_valid", ov8, 0);
        chk("async_rst_busy", busy8, 0);
        chk("async_rst_product", p8, 0);
        @(negedge clk); rst = 1;
        @(posedge clk); #1;
        op8(0, 8'd7, 8'd6, p, lat);
        chk("after_rst_product", p, 16'h002A);
        chk("after_rst_latency", lat, 6);

        op7(1, 7'h40, 7'h40, q, lat);
        chk("n7_signed_min", q, 14'h1000);
        chk("n7_latency", lat, 5);
        op7(0, 7'h7F, 7'h7F, q, lat);
        chk("n7_unsigned_max", q, 14'h3F01);

        for (int i = 0; i < 1000; i++) begin
            bit s;
            logic [7:0] a, b;
            s = 1'($urandom);
            a = 8'($urandom);
            b = 8'($urandom);
            op8(s, a, b, p, lat);
            chk($sformatf("rand8 s=%0d %h*%h", s, a, b), p, ref_mul(8, s, a, b));
            s = 1'($urandom);
            op7(s, a[6:0], b[6:0], q, lat);
            chk($sformatf("rand7 s=%0d %h*%h", s, a[6:0], b[6:0]), q, ref_mul(7, s, a, b));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
